// File: rtl/feature_window_reader.sv
// feature_window_reader: pops raster-ordered features from an FWFT head and emits 3x3 sliding windows.
// Latency: 1 cycle from accepting a window's bottom-right feature to win_valid.
// Backpressure: win_valid & ~win_ready freezes all outputs and withholds rd_en; 1 window/clk when ready.
// Optional: define STALL_CNT_EN to add the stall_cnt output (saturating count of back-pressured cycles).
module feature_window_reader #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                feature_valid,
  input  logic [DATA_W-1:0]   in_feature,
  output logic                rd_en,
  input  logic                win_ready,
  output logic                win_valid,
  output logic [9*DATA_W-1:0] win_data,
  output logic [15:0]         win_row,
  output logic [15:0]         win_col,
  output logic                frame_done
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  // Line-buffer address width; only the low bits of the column counter index the buffers.
  localparam int          CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);

  // Raster position of the next feature to be accepted.
  logic [15:0] col;
  logic [15:0] row;
  logic [CW-1:0] col_idx;

  // Two previous rows of features; lb1 holds row-1, lb2 holds row-2 at each column.
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;

  // Window register, element (i,j) at index 3*i+j; doubles as the win_data output.
  logic [8:0][DATA_W-1:0] win_q;
  logic [8:0][DATA_W-1:0] win_next;

  logic stall;
  logic accept;
  logic last_col;
  logic last_row;
  logic produce;

  assign col_idx  = col[CW-1:0];
  assign lb1_rd   = lb1[col_idx];
  assign lb2_rd   = lb2[col_idx];

  // A pending window that downstream has not taken blocks any further pop.
  assign stall    = win_valid & ~win_ready;
  assign rd_en    = rst & feature_valid & ~stall;
  assign accept   = rd_en;

  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

  // Columns 0 and 1 of a row still carry the previous row's tail in the window, so they never emit.
  assign produce  = (row >= 16'd2) && (col >= 16'd2);

  // Shift left by one column; the new right column is {row-2, row-1, current} at this column.
  assign win_next = {in_feature, win_q[8], win_q[7],
                     lb1_rd,     win_q[5], win_q[4],
                     lb2_rd,     win_q[2], win_q[1]};

  assign win_data = win_q;

  // Raster counters: advance on every accepted feature, wrapping at row and frame ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? 16'd0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // Line buffers carry no reset; stale data is never emitted because of the column/row gating.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_idx] <= lb1_rd;
      lb1[col_idx] <= in_feature;
    end
  end

  // Window register shifts once per accepted feature.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= '0;
    end else if (accept) begin
      win_q <= win_next;
    end
  end

  // Output handshake: a window is raised one cycle after its last feature and held until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
    end else if (accept) begin
      win_valid  <= produce;
      frame_done <= produce & last_row & last_col;
      if (produce) begin
        win_row <= row - 16'd1;
        win_col <= col - 16'd1;
      end
    end else if (win_valid && win_ready) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of cycles where a feature waited only because downstream held us off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (feature_valid && !rd_en && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_feature_window_reader.sv
// Bench for feature_window_reader: two instances (4x4 and 3x3 frames) driven from one FWFT source model.
// Expected windows are computed from the accepted feature stream by raster arithmetic.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_feature_window_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        feature_valid;
  logic [7:0]  in_feature;
  logic        win_ready;
  logic        sel;

  logic        fv_a, fv_b;
  logic        rd_en_a, rd_en_b;
  logic        wv_a, wv_b;
  logic [71:0] wd_a, wd_b;
  logic [15:0] wr_a, wr_b, wc_a, wc_b;
  logic        fd_a, fd_b;
`ifdef STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  logic        m_rd_en, m_win_valid, m_frame_done;
  logic [71:0] m_win_data;
  logic [15:0] m_win_row, m_win_col;

  assign fv_a         = feature_valid & ~sel;
  assign fv_b         = feature_valid & sel;
  assign m_rd_en      = sel ? rd_en_b : rd_en_a;
  assign m_win_valid  = sel ? wv_b : wv_a;
  assign m_win_data   = sel ? wd_b : wd_a;
  assign m_win_row    = sel ? wr_b : wr_a;
  assign m_win_col    = sel ? wc_b : wc_a;
  assign m_frame_done = sel ? fd_b : fd_a;

  feature_window_reader #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst(rst), .feature_valid(fv_a), .in_feature(in_feature), .rd_en(rd_en_a),
    .win_ready(win_ready), .win_valid(wv_a), .win_data(wd_a), .win_row(wr_a), .win_col(wc_a),
    .frame_done(fd_a)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  feature_window_reader #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut_b (
    .clk(clk), .rst(rst), .feature_valid(fv_b), .in_feature(in_feature), .rd_en(rd_en_b),
    .win_ready(win_ready), .win_valid(wv_b), .win_data(wd_b), .win_row(wr_b), .win_col(wc_b),
    .frame_done(fd_b)
`ifdef STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [71:0] WIN_F0 = 72'h0A_09_08_06_05_04_02_01_00;
  localparam logic [71:0] WIN_F1 = 72'h1A_19_18_16_15_14_12_11_10;
  localparam logic [71:0] WIN_3X3 = 72'h08_07_06_05_04_03_02_01_00;

  int n_chk = 0;
  int n_fail = 0;

  // FWFT source model and scoreboard state
  logic [7:0]  src_mem [4096];
  int          src_n, acc_n, win_idx, fd_cnt, mw, mh, cyc;
  logic        seen_first, fired_prev, want_win, stalled_prev;
  logic [71:0] prev_dat;
  logic [32:0] prev_pos;
  logic [71:0] win_log [64];
  logic [15:0] row_log [64];
  logic [15:0] col_log [64];
  logic        fd_log  [64];

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    src_n = 0; acc_n = 0; win_idx = 0; fd_cnt = 0;
    seen_first = 1'b0; fired_prev = 1'b0; want_win = 1'b0; stalled_prev = 1'b0;
  endtask

  // Window m (counted since reset) of a w x h raster stream: centre position and 3x3 data.
  task automatic exp_win(input int m, input int w, input int h, output logic [71:0] d,
                         output int er, output int ec, output logic efd);
    int per, k, q;
    per = (w - 2) * (h - 2);
    k   = m / per;
    q   = m % per;
    er  = q / (w - 2) + 1;
    ec  = q % (w - 2) + 1;
    efd = (q == per - 1);
    d   = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        d[(3*i+j)*8 +: 8] = src_mem[k*w*h + (er-1+i)*w + (ec-1+j)];
  endtask

  task automatic score();
    logic [71:0] ed;
    int er, ec;
    logic efd;
    exp_win(win_idx, mw, mh, ed, er, ec, efd);
    check("win_data", m_win_data, ed);
    check("win_row", 72'(m_win_row), 72'(er));
    check("win_col", 72'(m_win_col), 72'(ec));
    check("frame_done", 72'(m_frame_done), 72'(efd));
    if (win_idx < 64) begin
      win_log[win_idx] = m_win_data;
      row_log[win_idx] = m_win_row;
      col_log[win_idx] = m_win_col;
      fd_log[win_idx]  = m_frame_done;
    end
    if (m_frame_done) fd_cnt++;
    win_idx++;
  endtask

  // One clock: present FWFT head, check at the falling edge, advance the source on a pop.
  task automatic tick();
    logic fire;
    int q;
    in_feature = src_mem[src_n];
    @(negedge clk);
    check("rd_en", 72'(m_rd_en), 72'(rst && feature_valid && !(m_win_valid && !win_ready)));
    if (stalled_prev) begin
      check("hold_data", m_win_data, prev_dat);
      check("hold_pos", 72'({m_win_row, m_win_col, m_frame_done}), 72'(prev_pos));
    end
    if (fired_prev) check("latency", 72'(m_win_valid), 72'(want_win));
    if (rst && m_win_valid && !seen_first) begin
      check("first_win_accepts", 72'(acc_n), 72'(2*mw + 3));
      seen_first = 1'b1;
    end
    if (rst && m_win_valid && win_ready) score();
    stalled_prev = rst && m_win_valid && !win_ready;
    prev_dat = m_win_data;
    prev_pos = {m_win_row, m_win_col, m_frame_done};
    fire = m_rd_en;
    @(posedge clk);
    #1;
    cyc++;
    fired_prev = fire;
    if (fire) begin
      q = acc_n % (mw * mh);
      want_win = ((q / mw) >= 2) && ((q % mw) >= 2);
      acc_n++;
      src_n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_clear();
  endtask

  task automatic run_until(input int n, input int budget);
    int lim;
    lim = cyc + budget;
    while (acc_n < n && cyc < lim) tick();
    check("accept_progress", 72'(acc_n), 72'(n));
  endtask

  task automatic drain();
    feature_valid = 1'b0;
    win_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int lim, ph;
    logic [31:0] snap;
    for (int i = 0; i < 4096; i++) src_mem[i] = 8'(i);
    cyc = 0; mw = 4; mh = 4; sel = 1'b0;
    model_clear();
    rst = 1'b0; feature_valid = 1'b1; win_ready = 1'b0; in_feature = '0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst_win_valid", 72'(m_win_valid), 72'(0));
    check("rst_frame_done", 72'(m_frame_done), 72'(0));
    check("rst_win_data", m_win_data, 72'(0));
    check("rst_win_row", 72'(m_win_row), 72'(0));
    check("rst_win_col", 72'(m_win_col), 72'(0));
    check("rst_rd_en", 72'(m_rd_en), 72'(0));
    #2; rst = 1'b1; model_clear();

    // Continuous single frame
    feature_valid = 1'b1; win_ready = 1'b1;
    run_until(16, 100);
    drain();
    check("f1_windows", 72'(win_idx), 72'(4));
    check("f1_frame_done_cnt", 72'(fd_cnt), 72'(1));
    check("f1_first_data", win_log[0], WIN_F0);
    check("f1_first_row", 72'(row_log[0]), 72'(1));
    check("f1_first_col", 72'(col_log[0]), 72'(1));
    check("f1_fd_first", 72'(fd_log[0]), 72'(0));
    check("f1_fd_last", 72'(fd_log[3]), 72'(1));

    // Back-to-back second frame with a 5-cycle downstream stall on its first window
    feature_valid = 1'b1; win_ready = 1'b1;
    lim = cyc + 100;
    while (!m_win_valid && cyc < lim) tick();
    check("f2_first_valid", 72'(m_win_valid), 72'(1));
    win_ready = 1'b0;
    repeat (5) tick();
    win_ready = 1'b1;
    tick();
    run_until(32, 100);
    drain();
    check("f2_windows", 72'(win_idx), 72'(8));
    check("f2_centre_after_stall", 72'(win_log[5][39:32]), 72'(8'h16));
    check("f2_frame_done_cnt", 72'(fd_cnt), 72'(2));

    // Bursting FWFT: 10 cycles valid, 5 idle, two frames
    do_reset();
    win_ready = 1'b1; ph = 0;
    lim = cyc + 300;
    while (acc_n < 32 && cyc < lim) begin
      feature_valid = (ph % 15) < 10;
      ph++;
      tick();
    end
    check("burst_progress", 72'(acc_n), 72'(32));
    drain();
    check("burst_windows", 72'(win_idx), 72'(8));
    check("burst_f0_data", win_log[0], WIN_F0);
    check("burst_f1_data", win_log[4], WIN_F1);

    // Asynchronous reset in the middle of row 2
    do_reset();
    feature_valid = 1'b1; win_ready = 1'b1;
    run_until(11, 100);
    check("pre_rst_valid", 72'(m_win_valid), 72'(1));
    rst = 1'b0;
    #1;
    check("arst_win_valid", 72'(m_win_valid), 72'(0));
    check("arst_frame_done", 72'(m_frame_done), 72'(0));
    check("arst_rd_en", 72'(m_rd_en), 72'(0));
    check("arst_win_data", m_win_data, 72'(0));
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1; model_clear();
    run_until(16, 100);
    drain();
    check("arst_windows", 72'(win_idx), 72'(4));
    check("arst_first_data", win_log[0], WIN_F0);

    // Minimum 3x3 frame size, two frames
    sel = 1'b1; mw = 3; mh = 3;
    model_clear();
    feature_valid = 1'b1; win_ready = 1'b1;
    run_until(18, 100);
    drain();
    check("min_windows", 72'(win_idx), 72'(2));
    check("min_frame_done_cnt", 72'(fd_cnt), 72'(2));
    check("min_data", win_log[0], WIN_3X3);
    check("min_fd", 72'(fd_log[0]), 72'(1));

    // Random data with random FWFT bursts and random downstream ready
    sel = 1'b0; mw = 4; mh = 4;
    do_reset();
    for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom);
    lim = cyc + 2000;
    while (acc_n < 80 && cyc < lim) begin
      feature_valid = ($urandom_range(0, 9) < 7);
      win_ready     = ($urandom_range(0, 9) < 6);
      tick();
    end
    check("rand_progress", 72'(acc_n), 72'(80));
    drain();
    check("rand_windows", 72'(win_idx), 72'(20));
    check("rand_frame_done_cnt", 72'(fd_cnt), 72'(5));

`ifdef STALL_CNT_EN
    // Back-pressure counter over a 7-cycle stall
    do_reset();
    feature_valid = 1'b1; win_ready = 1'b1;
    run_until(11, 100);
    check("sc_valid", 72'(m_win_valid), 72'(1));
    snap = stall_a;
    win_ready = 1'b0;
    repeat (7) tick();
    check("stall_cnt_delta", 72'(stall_a - snap), 72'(7));
    drain();
`else
    snap = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
